// File: rtl/reg_logic_pipe.sv
// reg_logic_pipe
//   Delays operand in1 through DEPTH register stages (each stage carries a
//   valid bit), then combines the chain tail with the live operand in2 using
//   a selectable bitwise op and registers the result.
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   en        : advance enable (0 = hold every register)
//   flush     : synchronous clear of all pipe contents, wins over en
//   in_valid  : qualifies in1 this cycle
//   in1       : delayed operand (WIDTH)
//   in2       : live operand, sampled at the output stage (WIDTH)
//   mode      : 00 AND, 01 OR, 10 XOR, 11 NAND, sampled with in2
//   out       : registered result (WIDTH)
//   out_valid : out is derived from a valid in1
//   fill_cnt  : number of valid entries in stages 0..DEPTH-1 (CW)
//
// Handshake: in_valid is a plain qualifier with no ready. When en=0 the
// input is ignored, so upstream must hold its item until en=1.
module reg_logic_pipe #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CW-1:0]    fill_cnt
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("reg_logic_pipe: DEPTH must be at least 1");
  end

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  logic [DEPTH-1:0][WIDTH-1:0] stg_data_q, stg_data_d;
  logic [DEPTH-1:0]            stg_vld_q,  stg_vld_d;
  logic [WIDTH-1:0]            out_q,      out_d;
  logic                        out_vld_q,  out_vld_d;
  logic [CW-1:0]               fill_cnt_q, fill_cnt_d;

  logic [WIDTH-1:0]            tail_data;
  logic                        tail_vld;
  logic [WIDTH-1:0]            op_res;

  assign tail_data = stg_data_q[DEPTH-1];
  assign tail_vld  = stg_vld_q[DEPTH-1];

  // Bitwise op between chain tail and live operand; every mode is legal.
  always_comb begin
    op_res = tail_data & in2;
    case (mode)
      MODE_AND:  op_res = tail_data & in2;
      MODE_OR:   op_res = tail_data | in2;
      MODE_XOR:  op_res = tail_data ^ in2;
      MODE_NAND: op_res = ~(tail_data & in2);
      default:   op_res = tail_data & in2;
    endcase
  end

  always_comb begin
    stg_data_d = stg_data_q;
    stg_vld_d  = stg_vld_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    fill_cnt_d = fill_cnt_q;

    if (flush) begin
      stg_data_d = '0;
      stg_vld_d  = '0;
      out_d      = '0;
      out_vld_d  = 1'b0;
      fill_cnt_d = '0;
    end else if (en) begin
      // Bubbles enter as zero data so an invalid slot never leaks stale bits.
      stg_data_d[0] = in_valid ? in1 : '0;
      stg_vld_d[0]  = in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        stg_data_d[k] = stg_data_q[k-1];
        stg_vld_d[k]  = stg_vld_q[k-1];
      end
      out_d     = op_res;
      out_vld_d = tail_vld;
      // A full chain always retires its tail on the same edge, so the count
      // never leaves 0..DEPTH and modular CW-bit arithmetic is exact.
      fill_cnt_d = fill_cnt_q + CW'(in_valid) - CW'(tail_vld);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_data_q <= '0;
      stg_vld_q  <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      fill_cnt_q <= '0;
    end else begin
      stg_data_q <= stg_data_d;
      stg_vld_q  <= stg_vld_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_vld_q;
  assign fill_cnt  = fill_cnt_q;

endmodule
